// File: rtl/ecpu_pkg.sv
// Shared definitions for the ecpu fetch stage: instruction width, field layout,
// opcode encoding and fetch state type.
package ecpu_pkg;

  localparam int unsigned IW = 42;
  localparam int unsigned AW = 8;

  localparam int unsigned IMM_SEL_BIT = 41;
  localparam int unsigned OPC_HI      = 40;
  localparam int unsigned OPC_LO      = 36;
  localparam int unsigned ADDR_HI     = 35;
  localparam int unsigned ADDR_LO     = 28;
  localparam int unsigned REG_HI      = 27;
  localparam int unsigned REG_LO      = 25;
  localparam int unsigned RSVD_BIT    = 24;
  localparam int unsigned IMM_HI      = 23;
  localparam int unsigned IMM_LO      = 0;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_LOAD  = 5'd1,
    OP_STORE = 5'd2,
    OP_ADD   = 5'd3,
    OP_JMP   = 5'd4,
    OP_JZ    = 5'd5,
    OP_SUB   = 5'd6,
    OP_OUT   = 5'd7,
    OP_HALT  = 5'd31
  } opcode_e;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t ST_RUN    = 1'b0;
  localparam fetch_state_t ST_HALTED = 1'b1;

endpackage

// File: rtl/ecpu_fetch.sv
// Instruction fetch stage: pc, registered instruction word with valid/ready
// handshake, redirect on jump, terminal halt, inline field slicer.
module ecpu_fetch #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned IW       = ecpu_pkg::IW
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [7:0]    rom_addr,
  input  logic [IW-1:0] rom_data,
  input  logic          jmp_en,
  input  logic [7:0]    jmp_target,
  input  logic          halt_req,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [IW-1:0] ir,
  output logic [7:0]    ir_pc,
  output logic          ir_imm_sel,
  output logic [4:0]    ir_opcode,
  output logic [7:0]    ir_addr,
  output logic [2:0]    ir_reg,
  output logic [23:0]   ir_imm,
  output logic          halted
);

  import ecpu_pkg::fetch_state_t;
  import ecpu_pkg::ST_RUN;
  import ecpu_pkg::ST_HALTED;

  fetch_state_t  state_q, state_d;
  logic [7:0]    pc_q, pc_d;
  logic [IW-1:0] ir_d;
  logic [7:0]    ir_pc_d;
  logic          ir_valid_d;

  // State and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      ir       <= '0;
      ir_pc    <= 8'h00;
      ir_valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir       <= ir_d;
      ir_pc    <= ir_pc_d;
      ir_valid <= ir_valid_d;
    end
  end

  // Next-state: halt beats jump, jump beats stall, otherwise fetch when the slot frees
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir;
    ir_pc_d    = ir_pc;
    ir_valid_d = ir_valid;
    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d    = ST_HALTED;
          ir_valid_d = 1'b0;
        end else if (jmp_en) begin
          pc_d       = jmp_target;
          ir_valid_d = 1'b0;
        end else if (!ir_valid || ir_ready) begin
          ir_d       = rom_data;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          pc_d       = pc_q + 8'd1;
        end
      end
      ST_HALTED: begin
        ir_valid_d = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign rom_addr = pc_q;
  assign halted   = (state_q == ST_HALTED);

  assign ir_imm_sel = ir[ecpu_pkg::IMM_SEL_BIT];
  assign ir_opcode  = ir[ecpu_pkg::OPC_HI:ecpu_pkg::OPC_LO];
  assign ir_addr    = ir[ecpu_pkg::ADDR_HI:ecpu_pkg::ADDR_LO];
  assign ir_reg     = ir[ecpu_pkg::REG_HI:ecpu_pkg::REG_LO];
  assign ir_imm     = ir[ecpu_pkg::IMM_HI:ecpu_pkg::IMM_LO];

endmodule

// File: tb/tb_ecpu_fetch.sv
// Self-checking bench for ecpu_fetch: directed scenarios plus randomized
// ready/jump traffic, compared against a cycle-level behavioural model.
module tb_ecpu_fetch;

  localparam logic [7:0] RESET_PC = 8'h00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [41:0] rom_data;
  logic        jmp_en;
  logic [7:0]  jmp_target;
  logic        halt_req;
  logic        ir_valid;
  logic        ir_ready;
  logic [41:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_imm_sel;
  logic [4:0]  ir_opcode;
  logic [7:0]  ir_addr;
  logic [2:0]  ir_reg;
  logic [23:0] ir_imm;
  logic        halted;

  logic [41:0] rom [256];

  // Reference model state
  logic [7:0]  m_pc;
  logic [41:0] m_ir;
  logic [7:0]  m_ir_pc;
  logic        m_valid;
  logic        m_halted;

  int checks = 0;
  int passed = 0;

  ecpu_fetch #(.RESET_PC(RESET_PC), .IW(42)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .jmp_en(jmp_en), .jmp_target(jmp_target), .halt_req(halt_req),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc),
    .ir_imm_sel(ir_imm_sel), .ir_opcode(ir_opcode), .ir_addr(ir_addr),
    .ir_reg(ir_reg), .ir_imm(ir_imm), .halted(halted)
  );

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_ir = '0; m_ir_pc = 8'h00; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // One rising edge of the specified behaviour, using the inputs presented at that edge
  task automatic model_edge();
    if (!rst_n) model_reset();
    else if (!m_halted) begin
      if (halt_req) begin
        m_halted = 1'b1; m_valid = 1'b0;
      end else if (jmp_en) begin
        m_pc = jmp_target; m_valid = 1'b0;
      end else if (!m_valid || ir_ready) begin
        m_ir = rom[m_pc]; m_ir_pc = m_pc; m_valid = 1'b1;
        m_pc = 8'((int'(m_pc) + 1) % 256);
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rom_addr"}, 64'(rom_addr), 64'(m_pc));
    chk({tag, ".ir_valid"}, 64'(ir_valid), 64'(m_valid));
    chk({tag, ".halted"}, 64'(halted), 64'(m_halted));
    chk({tag, ".ir"}, 64'(ir), 64'(m_ir));
    chk({tag, ".ir_pc"}, 64'(ir_pc), 64'(m_ir_pc));
    chk({tag, ".imm_sel"}, 64'(ir_imm_sel), 64'(m_ir[41]));
    chk({tag, ".opcode"}, 64'(ir_opcode), 64'(m_ir[40:36]));
    chk({tag, ".addr"}, 64'(ir_addr), 64'(m_ir[35:28]));
    chk({tag, ".reg"}, 64'(ir_reg), 64'(m_ir[27:25]));
    chk({tag, ".imm"}, 64'(ir_imm), 64'(m_ir[23:0]));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed mid-cycle, released before the next rising edge
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  frozen;
    logic [41:0] fword;

    rst_n = 1'b0; ir_ready = 1'b0; jmp_en = 1'b0; jmp_target = 8'h00; halt_req = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 42'({$urandom(), $urandom()});
    fword = {1'b1, 5'd4, 8'hFF, 3'd0, 1'b0, 24'd1};
    rom[8'h80] = fword;

    #2;
    model_reset();
    check_all("reset");
    step("reset_held");

    // Straight-line fetch A,B,C,D
    rst_n = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("seq");
      chk($sformatf("seq%0d.ir", i), 64'(ir), 64'(rom[i]));
      chk($sformatf("seq%0d.ir_pc", i), 64'(ir_pc), 64'(i));
      chk($sformatf("seq%0d.valid", i), 64'(ir_valid), 64'd1);
    end

    // Stall while holding B, then resume to C
    do_reset();
    step("to_a");
    step("to_b");
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("stall");
      chk("stall.ir_pc", 64'(ir_pc), 64'd1);
      chk("stall.rom_addr", 64'(rom_addr), 64'd2);
      chk("stall.ir", 64'(ir), 64'(rom[1]));
    end
    ir_ready = 1'b1;
    step("resume");
    chk("resume.ir", 64'(ir), 64'(rom[2]));
    chk("resume.ir_pc", 64'(ir_pc), 64'd2);

    // Jump while stalled
    ir_ready = 1'b0;
    step("pre_jmp_stall");
    jmp_en = 1'b1; jmp_target = 8'h40;
    step("jmp");
    jmp_en = 1'b0;
    chk("jmp.valid", 64'(ir_valid), 64'd0);
    chk("jmp.rom_addr", 64'(rom_addr), 64'h40);
    step("jmp_land");
    chk("jmp_land.ir", 64'(ir), 64'(rom[8'h40]));
    chk("jmp_land.ir_pc", 64'(ir_pc), 64'h40);

    // Randomized ready/jump traffic
    for (int i = 0; i < 300; i++) begin
      ir_ready   = ($urandom_range(0, 9) < 7);
      jmp_en     = ($urandom_range(0, 19) == 0);
      jmp_target = 8'($urandom());
      step("rand");
    end

    // pc wrap FF -> 00
    jmp_en = 1'b1; jmp_target = 8'hFE; ir_ready = 1'b1;
    step("wrap_jmp");
    jmp_en = 1'b0;
    step("wrap_fe");
    step("wrap_ff");
    chk("wrap.ir_pc_ff", 64'(ir_pc), 64'hFF);
    step("wrap_00");
    chk("wrap.ir_pc_00", 64'(ir_pc), 64'h00);

    // Field slicing on a known word
    jmp_en = 1'b1; jmp_target = 8'h80;
    step("fld_jmp");
    jmp_en = 1'b0;
    step("fld_load");
    chk("fld.imm_sel", 64'(ir_imm_sel), 64'd1);
    chk("fld.opcode", 64'(ir_opcode), 64'd4);
    chk("fld.addr", 64'(ir_addr), 64'hFF);
    chk("fld.reg", 64'(ir_reg), 64'd0);
    chk("fld.imm", 64'(ir_imm), 64'd1);

    // Halt wins over a simultaneous jump; fetch stays frozen
    step("pre_halt");
    frozen = m_pc;
    halt_req = 1'b1; jmp_en = 1'b1; jmp_target = 8'h10;
    step("halt");
    halt_req = 1'b0; jmp_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ir_ready   = 1'($urandom_range(0, 1));
      jmp_en     = 1'($urandom_range(0, 1));
      jmp_target = 8'($urandom());
      step("halted");
      chk("halted.flag", 64'(halted), 64'd1);
      chk("halted.valid", 64'(ir_valid), 64'd0);
      chk("halted.rom_addr", 64'(rom_addr), 64'(frozen));
    end
    jmp_en = 1'b0; ir_ready = 1'b1;

    // Reset leaves HALTED and restarts from RESET_PC
    do_reset();
    step("restart");
    chk("restart.ir_pc", 64'(ir_pc), 64'(RESET_PC));
    chk("restart.ir", 64'(ir), 64'(rom[RESET_PC]));
    chk("restart.halted", 64'(halted), 64'd0);

    // Reset during a stall with a jump pending discards both
    step("pre_stall");
    ir_ready = 1'b0; jmp_en = 1'b1; jmp_target = 8'hC3;
    do_reset();
    jmp_en = 1'b0; ir_ready = 1'b1;
    step("rst_mid");
    chk("rst_mid.ir_pc", 64'(ir_pc), 64'(RESET_PC));
    step("rst_mid2");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
